// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared constants and state type for the text console writer
package text_console_pkg;

    localparam int COLS_DEF  = 40;
    localparam int ROWS_DEF  = 30;
    localparam int COL_W_DEF = 6;
    localparam int ROW_W_DEF = 5;

    localparam logic [7:0] CHR_BS       = 8'h08;
    localparam logic [7:0] CHR_LF       = 8'h0A;
    localparam logic [7:0] CHR_FF       = 8'h0C;
    localparam logic [7:0] CHR_CR       = 8'h0D;
    localparam logic [7:0] CHR_SPACE    = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLEAR_LINE = 2'd1,
        ST_CLEAR_ALL  = 2'd2
    } state_e;

    // Glyph range that is drawn; everything else is a control or ignored
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHR_SPACE) && (b <= CHR_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_clear_sweep.sv
// rtl/text_clear_sweep.sv - row/column sweep counter shared by line and screen clears
module text_clear_sweep
    import text_console_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_line,
    input  logic             start_all,
    input  logic             step,
    input  logic             all_mode,
    output logic [COL_W-1:0] clr_col,
    output logic [ROW_W-1:0] clr_row,
    output logic             done
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_col;
    logic             last_row;

    assign last_col = (col_q == COL_W'(COLS - 1));
    assign last_row = (row_q == ROW_W'(ROWS - 1));
    // A line clear ends at the last column; a screen clear also needs the last row
    assign done     = last_col && (!all_mode || last_row);
    assign clr_col  = col_q;
    assign clr_row  = row_q;

    // Next sweep position: restart requests win over stepping
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_all) begin
            col_d = '0;
            row_d = '0;
        end else if (start_line) begin
            col_d = '0;
        end else if (step) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Sweep position register
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte-stream terminal that fills the text-mode character RAM
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter int         COL_W = COL_W_DEF,
    parameter int         ROW_W = ROW_W_DEF,
    parameter logic [7:0] FILL  = CHR_SPACE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [COL_W+ROW_W-1:0] wr_addr,
    output logic [7:0]             wr_data,
    output logic [COL_W-1:0]       cur_col,
    output logic [ROW_W-1:0]       cur_row,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [COL_W-1:0]       cur_col_q, cur_col_d;
    logic [ROW_W-1:0]       cur_row_q, cur_row_d;
    logic                   wr_en_q, wr_en_d;
    logic [COL_W+ROW_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;

    logic                   start_line;
    logic                   start_all;
    logic                   step;
    logic [COL_W-1:0]       clr_col;
    logic [ROW_W-1:0]       clr_row;
    logic                   clr_done;

    logic                   accept;
    logic                   last_col;
    logic [ROW_W-1:0]       row_inc;
    logic [COL_W-1:0]       col_dec;

    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign last_col = (cur_col_q == COL_W'(COLS - 1));
    assign row_inc  = (cur_row_q == ROW_W'(ROWS - 1)) ? '0 : cur_row_q + ROW_W'(1);
    assign col_dec  = cur_col_q - COL_W'(1);

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cur_col  = cur_col_q;
    assign cur_row  = cur_row_q;
    assign busy     = (state_q != ST_IDLE);

    text_clear_sweep #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .start_line (start_line),
        .start_all  (start_all),
        .step       (step),
        .all_mode   (state_q == ST_CLEAR_ALL),
        .clr_col    (clr_col),
        .clr_row    (clr_row),
        .done       (clr_done)
    );

    // Byte interpretation, cursor movement and RAM write generation
    always_comb begin
        state_d    = state_q;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_line = 1'b0;
        start_all  = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {cur_row_q, cur_col_q};
                        wr_data_d = in_data;
                        if (last_col) begin
                            cur_col_d  = '0;
                            cur_row_d  = row_inc;
                            state_d    = ST_CLEAR_LINE;
                            start_line = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + COL_W'(1);
                        end
                    end else begin
                        case (in_data)
                            CHR_CR: cur_col_d = '0;
                            CHR_LF: begin
                                cur_col_d  = '0;
                                cur_row_d  = row_inc;
                                state_d    = ST_CLEAR_LINE;
                                start_line = 1'b1;
                            end
                            CHR_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = col_dec;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = {cur_row_q, col_dec};
                                    wr_data_d = FILL;
                                end
                            end
                            CHR_FF: begin
                                cur_col_d = '0;
                                cur_row_d = '0;
                                state_d   = ST_CLEAR_ALL;
                                start_all = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR_LINE: begin
                // The cursor already sits on the new line, so it supplies the row
                wr_en_d   = 1'b1;
                wr_addr_d = {cur_row_q, clr_col};
                wr_data_d = FILL;
                step      = 1'b1;
                if (clr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {clr_row, clr_col};
                wr_data_d = FILL;
                step      = 1'b1;
                if (clr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, cursor and registered RAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR_ALL;
            cur_col_q <= '0;
            cur_row_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule
